instr_mem_loadable: RTL

//  Parametrised instruction memory that supersedes the fixed, reset-preloaded

---
 rtl/instr_mem_loadable.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: clear sequencer after reset, registered fetch
// with read-before-write against a same-cycle load, and out-of-range flagging.
module instr_mem_loadable #(
   parameter int unsigned       ADDR_W         = 12,
   parameter int unsigned       DATA_W         = 19,
   parameter int unsigned       DEPTH          = 4096,
   parameter int unsigned       CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0] NOP_WORD       = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] instruction,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ack,
   output logic              addr_err
);

   localparam int unsigned      PTR_W   = ADDR_W + 1;
   localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

   state_t              state_q,       state_d;
   logic [PTR_W-1:0]    clr_ptr_q,     clr_ptr_d;
   logic                ready_q,       ready_d;
   logic                fetch_valid_q, fetch_valid_d;
   logic [DATA_W-1:0]   instruction_q, instruction_d;
   logic                load_ack_q,    load_ack_d;
   logic                addr_err_q,    addr_err_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                mem_we;
   logic [IDX_W-1:0]    mem_widx;
   logic [DATA_W-1:0]   mem_wdata;

   logic                fetch_oor;
   logic                load_oor;
   logic [IDX_W-1:0]    fetch_idx;
   logic [IDX_W-1:0]    load_idx;

   // Range decode; the extra top bit lets DEPTH == 2**ADDR_W compare cleanly.
   always_comb begin
      fetch_oor = ({1'b0, fetch_addr} >= DEPTH_P);
      load_oor  = ({1'b0, load_addr}  >= DEPTH_P);
      fetch_idx = IDX_W'(fetch_addr);
      load_idx  = IDX_W'(load_addr);
   end

   // Next-state: clear sweep, then service fetch and load together.
   always_comb begin
      state_d       = state_q;
      clr_ptr_d     = clr_ptr_q;
      fetch_valid_d = 1'b0;
      instruction_d = instruction_q;
      load_ack_d    = 1'b0;
      addr_err_d    = 1'b0;
      mem_we        = 1'b0;
      mem_widx      = '0;
      mem_wdata     = NOP_WORD;

      if (state_q == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_widx  = IDX_W'(clr_ptr_q);
         mem_wdata = NOP_WORD;
         clr_ptr_d = clr_ptr_q + PTR_W'(1);
         if (clr_ptr_q == LAST_P) begin
            state_d = S_READY;
         end
      end else if (ready_q) begin
         // Read uses the pre-edge array contents, so a same-address load
         // becomes visible only to the following fetch.
         if (fetch_req) begin
            fetch_valid_d = 1'b1;
            if (fetch_oor) begin
               instruction_d = NOP_WORD;
               addr_err_d    = 1'b1;
            end else begin
               instruction_d = mem_q[fetch_idx];
            end
         end
         if (load_en) begin
            load_ack_d = 1'b1;
            if (load_oor) begin
               addr_err_d = 1'b1;
            end else begin
               mem_we    = 1'b1;
               mem_widx  = load_idx;
               mem_wdata = load_data;
            end
         end
      end

      ready_d = (state_d == S_READY);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RST_STATE;
         clr_ptr_q     <= '0;
         ready_q       <= 1'b0;
         fetch_valid_q <= 1'b0;
         instruction_q <= NOP_WORD;
         load_ack_q    <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_ptr_q     <= clr_ptr_d;
         ready_q       <= ready_d;
         fetch_valid_q <= fetch_valid_d;
         instruction_q <= instruction_d;
         load_ack_q    <= load_ack_d;
         addr_err_q    <= addr_err_d;
      end
   end

   // Storage array; contents survive reset and are only cleared by the sweep.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

   assign ready       = ready_q;
   assign fetch_valid = fetch_valid_q;
   assign instruction = instruction_q;
   assign load_ack    = load_ack_q;
   assign addr_err    = addr_err_q;

endmodule
